// File: rtl/aes_stream_pkg.sv
// Shared word/block types for the AES plaintext stream path.
// Block words are numbered from the MSB end: word 0 is blk[0:31].
package aes_stream_pkg;

    localparam int unsigned WORD_W        = 32;
    localparam int unsigned WORDS_PER_BLK = 4;
    localparam int unsigned BLK_W         = WORD_W * WORDS_PER_BLK;

    typedef logic [0:BLK_W-1]  aes_blk_t;
    typedef logic [0:WORD_W-1] aes_word_t;

    function automatic aes_word_t blk_word(input aes_blk_t blk, input logic [1:0] idx);
        aes_word_t w_word;
        w_word = '0;
        case (idx)
            2'd0:    w_word = blk[0:31];
            2'd1:    w_word = blk[32:63];
            2'd2:    w_word = blk[64:95];
            default: w_word = blk[96:127];
        endcase
        return w_word;
    endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// DEPTH-entry FIFO of 128-bit blocks; fullness/emptiness is tracked by the level counter.
// Writes must already be qualified by the caller (no internal overflow protection).
module aes_blk_fifo
    import aes_stream_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  aes_blk_t                   wr_data,
    input  logic                       rd_pop,
    output aes_blk_t                   rd_data,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    aes_blk_t             r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [LVL_W-1:0]     r_level;
    logic [LVL_W-1:0]     w_level_d;

    // Storage carries no reset; validity is defined solely by r_level.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_comb begin
        w_level_d = r_level;
        if (wr_en && !rd_pop) begin
            w_level_d = r_level + LVL_W'(1);
        end else if (rd_pop && !wr_en) begin
            w_level_d = r_level - LVL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (rd_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_level <= w_level_d;
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign level   = r_level;

endmodule

// File: rtl/aes_pt_unpacker.sv
// Buffers decrypted 128-bit blocks and streams them out as four 32-bit words, MS word first.
// Define AES_PT_LAST_EN to add the dout_last block-boundary output.
module aes_pt_unpacker
    import aes_stream_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [0:127]               pt,
    input  logic                       pt_vld,
    output logic [0:31]                dout,
    output logic                       dout_vld,
    input  logic                       dout_rdy,
    output logic [$clog2(DEPTH+1)-1:0] ob_level,
    output logic                       ob_room,
    output logic                       ob_ovf
`ifdef AES_PT_LAST_EN
    ,
    output logic                       dout_last
`endif
);

    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic [LVL_W-1:0] w_level;
    aes_blk_t         w_head;
    logic             w_vld;
    logic             w_xfer;
    logic             w_pop;
    logic             w_room;
    logic             w_wr_en;
    logic [1:0]       r_idx;
    logic             r_ovf;

    assign w_vld   = (w_level != '0);
    assign w_xfer  = w_vld & dout_rdy;
    assign w_pop   = w_xfer & (r_idx == 2'd3);
    assign w_room  = (w_level < LVL_W'(DEPTH));
    // A full FIFO still accepts when the head leaves on the same edge.
    assign w_wr_en = pt_vld & (w_room | w_pop);

    aes_blk_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_wr_en),
        .wr_data (pt),
        .rd_pop  (w_pop),
        .rd_data (w_head),
        .level   (w_level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= 2'd0;
            r_ovf <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_idx <= r_idx + 2'd1;
            end
            if (pt_vld && !w_wr_en) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign dout     = w_vld ? blk_word(w_head, r_idx) : '0;
    assign dout_vld = w_vld;
    assign ob_level = w_level;
    assign ob_room  = w_room;
    assign ob_ovf   = r_ovf;

`ifdef AES_PT_LAST_EN
    assign dout_last = w_vld & (r_idx == 2'd3);
`endif

endmodule

// File: tb/tb_aes_pt_unpacker.sv
// Scoreboard bench for aes_pt_unpacker (DEPTH=2); checks dout_last when AES_PT_LAST_EN is defined.
module tb_aes_pt_unpacker;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic [0:127]     pt;
    logic             pt_vld;
    logic [0:31]      dout;
    logic             dout_vld;
    logic             dout_rdy;
    logic [LVL_W-1:0] ob_level;
    logic             ob_room;
    logic             ob_ovf;
`ifdef AES_PT_LAST_EN
    logic             dout_last;
`endif

    aes_pt_unpacker #(
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pt       (pt),
        .pt_vld   (pt_vld),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_rdy (dout_rdy),
        .ob_level (ob_level),
        .ob_room  (ob_room),
        .ob_ovf   (ob_ovf)
`ifdef AES_PT_LAST_EN
        ,
        .dout_last (dout_last)
`endif
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    int          m_level;
    int          m_idx;
    logic        m_ovf;

    localparam logic [127:0] BLK_P = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] BLK_A = 128'hAAAA0000_AAAA0001_AAAA0002_AAAA0003;
    localparam logic [127:0] BLK_B = 128'hBBBB0000_BBBB0001_BBBB0002_BBBB0003;
    localparam logic [127:0] BLK_C = 128'hCCCC0000_CCCC0001_CCCC0002_CCCC0003;
    localparam logic [127:0] BLK_D = 128'hDDDD0000_DDDD0001_DDDD0002_DDDD0003;
    localparam logic [127:0] BLK_E = 128'hEEEE0000_EEEE0001_EEEE0002_EEEE0003;
    localparam logic [127:0] BLK_1 = {128{1'b1}};

    // One clock: drive inputs, sample outputs before the edge, advance the model, return at edge+1.
    task automatic step(input logic vld, input logic [127:0] blk, input logic rdy,
                        output logic exp_vld, output logic exp_last, output logic obs_vld,
                        output logic [31:0] obs_word, output logic obs_last);
        logic xfer;
        logic pop;
        logic acc;
        pt_vld   = vld;
        pt       = blk;
        dout_rdy = rdy;
        #1;
        exp_vld  = (m_level != 0);
        exp_last = exp_vld && (m_idx == 3);
        obs_vld  = dout_vld;
        obs_word = dout;
`ifdef AES_PT_LAST_EN
        obs_last = dout_last;
`else
        obs_last = 1'b0;
`endif
        xfer = exp_vld && rdy;
        pop  = xfer && (m_idx == 3);
        acc  = vld && ((m_level < DEPTH) || pop);
        if (acc) begin
            exp_q.push_back(blk[127:96]);
            exp_q.push_back(blk[95:64]);
            exp_q.push_back(blk[63:32]);
            exp_q.push_back(blk[31:0]);
        end else if (vld) begin
            m_ovf = 1'b1;
        end
        m_level = m_level + (acc ? 1 : 0) - (pop ? 1 : 0);
        if (xfer) m_idx = (m_idx + 1) % 4;
        @(posedge clk);
        #1;
        pt_vld = 1'b0;
    endtask

    task automatic apply_reset();
        rst      = 1'b1;
        pt_vld   = 1'b0;
        pt       = '0;
        dout_rdy = 1'b0;
        exp_q.delete();
        m_level = 0;
        m_idx   = 0;
        m_ovf   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if (dout_vld !== 1'b0 || dout !== 32'h0) begin
            errors++;
            $display("FAIL reset_out: dout_vld=%b dout=%h, expected 0/0", dout_vld, dout);
        end
        checks++;
        if (ob_level !== '0 || ob_room !== 1'b1 || ob_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_stat: level=%0d room=%b ovf=%b, expected 0/1/0",
                     ob_level, ob_room, ob_ovf);
        end
`ifdef AES_PT_LAST_EN
        checks++;
        if (dout_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_last: dout_last=%b expected 0", dout_last);
        end
`endif
        apply_reset();
    endtask

    task automatic test_single_block();
        logic ev, el, ov, ol;
        logic [31:0] ow;
        logic [31:0] lit [4] = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
        step(1'b1, BLK_P, 1'b1, ev, el, ov, ow, ol);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0, 1'b1, ev, el, ov, ow, ol);
            checks++;
            if (ov !== ev) begin
                errors++;
                $display("FAIL single_vld[%0d]: dout_vld=%b expected %b", i, ov, ev);
            end
            if (i < 4) begin
                checks++;
                if (ow !== lit[i]) begin
                    errors++;
                    $display("FAIL single_word[%0d]: dout=%h expected %h", i, ow, lit[i]);
                end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
        end
        checks++;
        if (ob_level !== '0 || ow !== 32'h0) begin
            errors++;
            $display("FAIL single_empty: level=%0d dout=%h expected 0/0", ob_level, ow);
        end
    endtask

    task automatic test_back_to_back();
        logic ev, el, ov, ol;
        logic [31:0] ow;
        step(1'b1, BLK_A, 1'b0, ev, el, ov, ow, ol);
        step(1'b1, BLK_B, 1'b0, ev, el, ov, ow, ol);
        checks++;
        if (ob_level !== LVL_W'(2) || ob_room !== 1'b0) begin
            errors++;
            $display("FAIL b2b_full: level=%0d room=%b expected 2/0", ob_level, ob_room);
        end
        for (int i = 0; i < 9; i++) begin
            step(1'b0, '0, 1'b1, ev, el, ov, ow, ol);
            checks++;
            if (ov !== ev || (ev && ow !== exp_q[0]) || (!ev && ow !== 32'h0)) begin
                errors++;
                $display("FAIL b2b_word[%0d]: vld=%b dout=%h expected vld=%b dout=%h",
                         i, ov, ow, ev, ev ? exp_q[0] : 32'h0);
            end
`ifdef AES_PT_LAST_EN
            checks++;
            if (ol !== el) begin
                errors++;
                $display("FAIL b2b_last[%0d]: dout_last=%b expected %b", i, ol, el);
            end
`endif
            if (ev) void'(exp_q.pop_front());
        end
        checks++;
        if (ob_ovf !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ovf: ob_ovf=%b expected 0", ob_ovf);
        end
    endtask

    task automatic test_overflow();
        logic ev, el, ov, ol;
        logic [31:0] ow;
        step(1'b1, BLK_A, 1'b0, ev, el, ov, ow, ol);
        step(1'b1, BLK_B, 1'b0, ev, el, ov, ow, ol);
        step(1'b1, BLK_1, 1'b0, ev, el, ov, ow, ol);
        checks++;
        if (ob_ovf !== 1'b1 || ob_level !== LVL_W'(2)) begin
            errors++;
            $display("FAIL ovf_set: ovf=%b level=%0d expected 1/2", ob_ovf, ob_level);
        end
        for (int i = 0; i < 9; i++) begin
            step(1'b0, '0, 1'b1, ev, el, ov, ow, ol);
            checks++;
            if (ov !== ev || (ev && ow !== exp_q[0])) begin
                errors++;
                $display("FAIL ovf_word[%0d]: vld=%b dout=%h expected vld=%b dout=%h",
                         i, ov, ow, ev, ev ? exp_q[0] : 32'h0);
            end
            if (ev) void'(exp_q.pop_front());
        end
        checks++;
        if (ob_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: ob_ovf=%b expected 1", ob_ovf);
        end
        apply_reset();
    endtask

    task automatic test_full_pop_write();
        logic ev, el, ov, ol;
        logic [31:0] ow;
        step(1'b1, BLK_A, 1'b0, ev, el, ov, ow, ol);
        step(1'b1, BLK_B, 1'b0, ev, el, ov, ow, ol);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b1, ev, el, ov, ow, ol);
            if (ev) void'(exp_q.pop_front());
        end
        step(1'b1, BLK_C, 1'b1, ev, el, ov, ow, ol);
        checks++;
        if (ow !== 32'hAAAA0003) begin
            errors++;
            $display("FAIL fpw_a3: dout=%h expected aaaa0003", ow);
        end
        if (ev) void'(exp_q.pop_front());
        checks++;
        if (ob_level !== LVL_W'(2) || ob_ovf !== 1'b0) begin
            errors++;
            $display("FAIL fpw_stat: level=%0d ovf=%b expected 2/0", ob_level, ob_ovf);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, '0, 1'b1, ev, el, ov, ow, ol);
            checks++;
            if (ov !== ev || (ev && ow !== exp_q[0])) begin
                errors++;
                $display("FAIL fpw_word[%0d]: vld=%b dout=%h expected vld=%b dout=%h",
                         i, ov, ow, ev, ev ? exp_q[0] : 32'h0);
            end
            if (ev) void'(exp_q.pop_front());
        end
    endtask

    task automatic test_stall();
        logic ev, el, ov, ol;
        logic [31:0] ow;
        logic rdy;
        step(1'b1, BLK_D, 1'b0, ev, el, ov, ow, ol);
        for (int i = 0; i < 8; i++) begin
            rdy = (i % 2 == 0);
            step(1'b0, '0, rdy, ev, el, ov, ow, ol);
            checks++;
            if (ov !== ev || (ev && ow !== exp_q[0])) begin
                errors++;
                $display("FAIL stall_word[%0d]: vld=%b dout=%h expected vld=%b dout=%h",
                         i, ov, ow, ev, ev ? exp_q[0] : 32'h0);
            end
`ifdef AES_PT_LAST_EN
            checks++;
            if (ol !== el) begin
                errors++;
                $display("FAIL stall_last[%0d]: dout_last=%b expected %b", i, ol, el);
            end
`endif
            if (ev && rdy) void'(exp_q.pop_front());
        end
        checks++;
        if (ob_level !== '0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_end: level=%0d left=%0d expected 0/0", ob_level, exp_q.size());
        end
    endtask

    task automatic test_mid_reset();
        logic ev, el, ov, ol;
        logic [31:0] ow;
        step(1'b1, BLK_E, 1'b0, ev, el, ov, ow, ol);
        step(1'b1, BLK_A, 1'b0, ev, el, ov, ow, ol);
        step(1'b1, BLK_B, 1'b0, ev, el, ov, ow, ol);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, '0, 1'b1, ev, el, ov, ow, ol);
            if (ev) void'(exp_q.pop_front());
        end
        dout_rdy = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (dout_vld !== 1'b0 || ob_level !== '0 || ob_ovf !== 1'b0 || dout !== 32'h0) begin
            errors++;
            $display("FAIL mid_rst: vld=%b level=%0d ovf=%b dout=%h expected 0/0/0/0",
                     dout_vld, ob_level, ob_ovf, dout);
        end
        apply_reset();
        step(1'b1, BLK_C, 1'b0, ev, el, ov, ow, ol);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0, 1'b1, ev, el, ov, ow, ol);
            checks++;
            if (ov !== ev || (ev && ow !== exp_q[0])) begin
                errors++;
                $display("FAIL mid_word[%0d]: vld=%b dout=%h expected vld=%b dout=%h",
                         i, ov, ow, ev, ev ? exp_q[0] : 32'h0);
            end
`ifdef AES_PT_LAST_EN
            checks++;
            if (ol !== el) begin
                errors++;
                $display("FAIL mid_last[%0d]: dout_last=%b expected %b", i, ol, el);
            end
`endif
            if (ev) void'(exp_q.pop_front());
        end
    endtask

    task automatic test_random();
        logic ev, el, ov, ol;
        logic [31:0] ow;
        logic vld, rdy;
        logic [127:0] blk;
        for (int i = 0; i < 300; i++) begin
            vld = ($urandom_range(0, 2) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            blk = {$urandom, $urandom, $urandom, $urandom};
            step(vld, blk, rdy, ev, el, ov, ow, ol);
            checks++;
            if (ov !== ev || (ev && ow !== exp_q[0]) || (!ev && ow !== 32'h0)) begin
                errors++;
                $display("FAIL rnd_word[%0d]: vld=%b dout=%h expected vld=%b dout=%h",
                         i, ov, ow, ev, ev ? exp_q[0] : 32'h0);
            end
`ifdef AES_PT_LAST_EN
            checks++;
            if (ol !== el) begin
                errors++;
                $display("FAIL rnd_last[%0d]: dout_last=%b expected %b", i, ol, el);
            end
`endif
            if (ev && rdy) void'(exp_q.pop_front());
            checks++;
            if (ob_level !== LVL_W'(m_level) || ob_ovf !== m_ovf
                || ob_room !== (m_level < DEPTH)) begin
                errors++;
                $display("FAIL rnd_stat[%0d]: level=%0d ovf=%b room=%b expected %0d/%b/%b",
                         i, ob_level, ob_ovf, ob_room, m_level, m_ovf, (m_level < DEPTH));
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        pt       = '0;
        pt_vld   = 1'b0;
        dout_rdy = 1'b0;
        m_level  = 0;
        m_idx    = 0;
        m_ovf    = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_block();
        test_back_to_back();
        test_overflow();
        test_full_pop_write();
        test_stall();
        test_mid_reset();
        apply_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
